// File: rtl/neuron_acc_if.sv
// Bundle of the controller's command, term-stream, accumulator and result signals.
// The controller sits on the slave modport; the surrounding datapath on master.
interface neuron_acc_if #(
  parameter int CNT_W  = 8,
  parameter int DATA_W = 10,
  parameter int ACC_W  = 28
);
  logic              start;
  logic [CNT_W-1:0]  n_terms;
  logic              busy;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              acc_clr;
  logic              acc_ce;
  logic [DATA_W-1:0] acc_a;
  logic [ACC_W-1:0]  acc_y;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;

  modport master (
    output start, n_terms, in_valid, in_data, acc_y, res_ready,
    input  busy, in_ready, acc_clr, acc_ce, acc_a, res_valid, res_data
  );

  modport slave (
    input  start, n_terms, in_valid, in_data, acc_y, res_ready,
    output busy, in_ready, acc_clr, acc_ce, acc_a, res_valid, res_data
  );
endinterface

// File: rtl/neuron_acc_ctrl.sv
// Sequencer for one neuron accumulator: clear it, stream n_terms terms in,
// capture the sum and hold it on the result port until taken.
//
// state  | meaning
// IDLE   | waiting for start; only state where start is sampled
// CLEAR  | accumulator clears on this cycle's closing edge
// ACCUM  | accepting terms until the latched count is used up
// SETTLE | accumulator output is final; captured on the closing edge
// OUT    | result presented until the consumer handshake
module neuron_acc_ctrl #(
  parameter int CNT_W  = 8,
  parameter int DATA_W = 10,
  parameter int ACC_W  = 28
) (
  input logic         clk,
  input logic         rst,
  neuron_acc_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    ACCUM  = 3'd2,
    SETTLE = 3'd3,
    OUT    = 3'd4
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [ACC_W-1:0]   res_q, res_nx;
  logic               clr_q, clr_nx;

  // acc_clr resets high so the accumulator is held clear throughout reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      res_q <= '0;
      clr_q <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      res_q <= res_nx;
      clr_q <= clr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    res_nx   = res_q;
    clr_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          cnt_nx   = bus.n_terms;
          clr_nx   = 1'b1;
          state_nx = CLEAR;
        end
      end
      CLEAR: begin
        state_nx = (cnt == '0) ? SETTLE : ACCUM;
      end
      ACCUM: begin
        if (bus.in_valid) begin
          cnt_nx = cnt - 1'b1;
          if (cnt == CNT_W'(1)) state_nx = SETTLE;
        end
      end
      SETTLE: begin
        res_nx   = bus.acc_y;
        state_nx = OUT;
      end
      OUT: begin
        if (bus.res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.busy      = (state != IDLE);
  assign bus.in_ready  = (state == ACCUM);
  assign bus.res_valid = (state == OUT);
  assign bus.acc_clr   = clr_q;
  assign bus.acc_ce    = bus.in_valid & bus.in_ready;
  assign bus.acc_a     = bus.in_data[DATA_W-1:0];
  assign bus.res_data  = res_q;

endmodule

// File: tb/tb_neuron_acc_ctrl.sv
// Self-checking bench for neuron_acc_ctrl: a simple accumulator model is attached
// and each evaluation is checked against sums, counts and latencies computed here.
module tb_neuron_acc_ctrl;
  localparam int CNT_W  = 8;
  localparam int DATA_W = 10;
  localparam int ACC_W  = 28;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  neuron_acc_if #(.CNT_W(CNT_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  neuron_acc_ctrl #(.CNT_W(CNT_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Accumulator attached to the controller: synchronous clear, unsigned add.
  logic [ACC_W-1:0] acc_reg;
  always_ff @(posedge clk) begin
    if (bus.acc_clr) acc_reg <= '0;
    else if (bus.acc_ce) acc_reg <= acc_reg + ACC_W'(bus.acc_a);
  end
  assign bus.acc_y = acc_reg;

  int ce_count = 0;
  always @(posedge clk) if (bus.acc_ce === 1'b1) ce_count++;

  int checks   = 0;
  int failures = 0;
  logic [DATA_W-1:0] terms[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete evaluation using the terms queue. gap = idle cycles between
  // terms, bp = cycles of res_ready low in OUT, poke = stray start pulses.
  task automatic run_eval(input string tag, input int n, input int gap, input int bp, input bit poke);
    int edge_n, idx, lat, gap_left, ce0, exp_lat;
    bit xfer, hs, done;
    logic [31:0] exp_sum;
    logic [ACC_W-1:0] held;
    exp_sum = 0;
    for (int i = 0; i < n; i++) exp_sum += 32'(terms[i]);
    exp_sum = exp_sum & ((32'd1 << ACC_W) - 1);
    exp_lat = (n == 0) ? 3 : 3 + n + gap * (n - 1);
    ce0 = ce_count;
    edge_n = 0; idx = 0; gap_left = 0; lat = -1; done = 1'b0; held = '0;
    @(negedge clk);
    while (edge_n < 3000) begin
      if (edge_n > 0) begin
        if (done) begin
          check({tag, " busy_after"}, 32'(bus.busy), 0);
          check({tag, " res_valid_after"}, 32'(bus.res_valid), 0);
          check({tag, " ce_pulses"}, ce_count - ce0, n);
          break;
        end
        check({tag, " busy_during"}, 32'(bus.busy), 1);
        if (bus.res_valid === 1'b1 && lat < 0) begin
          lat  = edge_n;
          held = bus.res_data;
          check({tag, " latency"}, lat, exp_lat);
          check({tag, " res_data"}, 32'(bus.res_data), exp_sum);
        end else if (lat >= 0) begin
          check({tag, " hold_valid"}, 32'(bus.res_valid), 1);
          check({tag, " hold_data"}, 32'(bus.res_data), 32'(held));
        end
      end
      bus.start = (edge_n == 0) ||
                  (poke && (edge_n == 2 || (lat >= 0 && (edge_n == lat || edge_n - lat == bp))));
      bus.n_terms   = (edge_n == 0) ? CNT_W'(n) : CNT_W'($urandom);
      bus.res_ready = (lat >= 0) && (edge_n - lat >= bp);
      bus.in_valid  = (idx < n) && (gap_left == 0);
      bus.in_data   = (idx < n) ? terms[idx] : DATA_W'($urandom);
      #1;
      xfer = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
      hs   = (bus.res_valid === 1'b1) && bus.res_ready;
      if (xfer) check({tag, " acc_a"}, 32'(bus.acc_a), 32'(terms[idx]));
      @(posedge clk);
      edge_n++;
      if (xfer) begin
        idx++;
        gap_left = gap;
      end else if (gap_left > 0) begin
        gap_left--;
      end
      if (hs) done = 1'b1;
      @(negedge clk);
    end
    if (!done) check({tag, " timeout"}, 0, 1);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int ce0, n, gap, bp;
    bit poke;
    rst = 1'b1;
    bus.start = 1'b0; bus.n_terms = '0; bus.in_valid = 1'b0;
    bus.in_data = '0; bus.res_ready = 1'b0;

    // T1 reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t1 acc_clr", 32'(bus.acc_clr), 1);
    check("t1 busy", 32'(bus.busy), 0);
    check("t1 res_valid", 32'(bus.res_valid), 0);
    check("t1 in_ready", 32'(bus.in_ready), 0);
    check("t1 res_data", 32'(bus.res_data), 0);
    rst = 1'b0;
    bus.in_valid = 1'b1;
    #1;
    check("t1 ce_idle", 32'(bus.acc_ce), 0);
    @(posedge clk); #1;
    check("t1 acc_clr_release", 32'(bus.acc_clr), 0);
    bus.in_valid = 1'b0;

    // T2 basic
    terms = '{10'd1, 10'd2, 10'd3, 10'd4};
    run_eval("t2", 4, 0, 0, 1'b0);

    // T3 stalls
    terms = '{10'h3FF, 10'd5, 10'd7};
    run_eval("t3", 3, 2, 0, 1'b0);

    // T4 zero terms
    terms = '{};
    run_eval("t4", 0, 0, 0, 1'b0);

    // T5 backpressure with stray start pulses
    terms = '{10'd100, 10'd200, 10'd300};
    run_eval("t5", 3, 0, 5, 1'b1);

    // T6 reset mid-run
    ce0 = ce_count;
    @(negedge clk);
    bus.start = 1'b1; bus.n_terms = 8'd8;
    bus.in_valid = 1'b1; bus.in_data = DATA_W'($urandom);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      if (ce_count - ce0 >= 3) break;
      bus.in_data = DATA_W'($urandom);
    end
    check("t6 transfers", ce_count - ce0, 3);
    rst = 1'b1;
    #1;
    check("t6 busy", 32'(bus.busy), 0);
    check("t6 res_valid", 32'(bus.res_valid), 0);
    check("t6 in_ready", 32'(bus.in_ready), 0);
    check("t6 acc_clr", 32'(bus.acc_clr), 1);
    check("t6 acc_ce", 32'(bus.acc_ce), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    terms = '{10'd6, 10'd9};
    run_eval("t6 rerun", 2, 0, 0, 1'b0);

    // randomized evaluations
    for (int r = 0; r < 8; r++) begin
      n    = $urandom_range(0, 20);
      gap  = $urandom_range(0, 2);
      bp   = $urandom_range(0, 3);
      poke = 1'($urandom_range(0, 1));
      terms = '{};
      for (int i = 0; i < n; i++) terms.push_back(DATA_W'($urandom));
      run_eval($sformatf("rand%0d", r), n, gap, bp, poke);
    end

    // maximum term count
    terms = '{};
    for (int i = 0; i < 255; i++) terms.push_back(DATA_W'($urandom));
    run_eval("max", 255, 0, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
